// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, decode helpers and enums for the keypad debouncer
//
// Purpose: single source for the keypad scan/read encodings, the column/row
// decode helpers, the debounce FSM state type and the per-round result type.
// Ports: none (package).
package keypad_pkg;

  // Active-low column drive patterns, column 0..3.
  localparam logic [3:0] SCAN_COL0 = 4'b1110;
  localparam logic [3:0] SCAN_COL1 = 4'b1101;
  localparam logic [3:0] SCAN_COL2 = 4'b1011;
  localparam logic [3:0] SCAN_COL3 = 4'b0111;

  // Active-low row sense patterns, row 0..3 (row 0 is the MSB).
  localparam logic [3:0] READ_ROW0 = 4'b0111;
  localparam logic [3:0] READ_ROW1 = 4'b1011;
  localparam logic [3:0] READ_ROW2 = 4'b1101;
  localparam logic [3:0] READ_ROW3 = 4'b1110;
  localparam logic [3:0] READ_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } key_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } round_res_e;

  function automatic logic scan_is_valid(input logic [3:0] s);
    return (s == SCAN_COL0) || (s == SCAN_COL1) || (s == SCAN_COL2) || (s == SCAN_COL3);
  endfunction

  function automatic logic [1:0] scan_to_col(input logic [3:0] s);
    logic [1:0] col;
    case (s)
      SCAN_COL1: col = 2'd1;
      SCAN_COL2: col = 2'd2;
      SCAN_COL3: col = 2'd3;
      default:   col = 2'd0;
    endcase
    return col;
  endfunction

  function automatic logic read_is_single(input logic [3:0] r);
    return (r == READ_ROW0) || (r == READ_ROW1) || (r == READ_ROW2) || (r == READ_ROW3);
  endfunction

  function automatic logic [1:0] read_to_row(input logic [3:0] r);
    logic [1:0] row;
    case (r)
      READ_ROW1: row = 2'd1;
      READ_ROW2: row = 2'd2;
      READ_ROW3: row = 2'd3;
      default:   row = 2'd0;
    endcase
    return row;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/keypad_key_debounce_if.sv
// rtl/keypad_key_debounce_if.sv - keypad scan bus plus debounced key event outputs
//
// Purpose: bundles the scanner-side inputs and the key event outputs.
// Signals:
//   scan      [3:0] active-low column drive from the scanner
//   read      [3:0] active-low row sense from the keypad
//   key_code  [3:0] hex value of the last accepted key
//   key_valid       1-cycle strobe, key_code newly accepted or repeated
//   key_held        high while the accepted key remains pressed
//   multi_err       1-cycle strobe, a round ended with more than one key
// Modports: master drives scan/read (scanner side), slave is the debouncer.
interface keypad_key_debounce_if;
  logic [3:0] scan;
  logic [3:0] read;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  modport master (
    output scan,
    output read,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  multi_err
  );

  modport slave (
    input  scan,
    input  read,
    output key_code,
    output key_valid,
    output key_held,
    output multi_err
  );
endinterface

// File: rtl/keypad_round_sampler.sv
// rtl/keypad_round_sampler.sv - settle timing, per-phase read sampling and round result
//
// Purpose: watches the column drive, waits SETTLE_CYC cycles after every
// change, samples the row sense once per phase and summarises each complete
// scan round as NONE / ONE(code) / MULTI.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   scan [3:0]        active-low column drive
//   read [3:0]        active-low row sense
//   round_done        1-cycle strobe, a complete round just ended
//   round_res         result of that round
//   round_code [3:0]  key code {row,col} when round_res is ONE
module keypad_round_sampler
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] scan,
  input  logic [3:0] read,
  output logic       round_done,
  output round_res_e round_res,
  output logic [3:0] round_code
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SETTLE_SAT  = SW'(SETTLE_CYC);

  logic [3:0]    scan_q, scan_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    col_seen_q, col_seen_d;
  logic          hit_q, hit_d;
  logic          multi_q, multi_d;
  logic [3:0]    code_q, code_d;
  logic          round_done_q, round_done_d;
  round_res_e    round_res_q, round_res_d;
  logic [3:0]    round_code_q, round_code_d;

  always_comb begin
    scan_d       = scan;
    settle_d     = settle_q;
    col_seen_d   = col_seen_q;
    hit_d        = hit_q;
    multi_d      = multi_q;
    code_d       = code_q;
    round_done_d = 1'b0;
    round_res_d  = round_res_q;
    round_code_d = round_code_q;

    if (scan != scan_q) begin
      settle_d = '0;
      // Entering column 0 closes the round; only a round with every column
      // sampled is reported, anything partial is silently dropped.
      if (scan == SCAN_COL0) begin
        if (col_seen_q == 4'hF) begin
          round_done_d = 1'b1;
          round_code_d = code_q;
          if (multi_q) begin
            round_res_d = RES_MULTI;
          end else if (hit_q) begin
            round_res_d = RES_ONE;
          end else begin
            round_res_d = RES_NONE;
          end
        end
        col_seen_d = '0;
        hit_d      = 1'b0;
        multi_d    = 1'b0;
        code_d     = '0;
      end
    end else if (settle_q != SETTLE_SAT) begin
      // Counter parks at SETTLE_CYC so the read is taken exactly once per phase.
      settle_d = settle_q + 1'b1;
      if ((settle_q == SETTLE_LAST) && scan_is_valid(scan_q)) begin
        col_seen_d[scan_to_col(scan_q)] = 1'b1;
        if (read != READ_NONE) begin
          if (read_is_single(read)) begin
            // A second hit anywhere in the round makes it ambiguous.
            if (hit_q) begin
              multi_d = 1'b1;
            end else begin
              hit_d  = 1'b1;
              code_d = {read_to_row(read), scan_to_col(scan_q)};
            end
          end else begin
            multi_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scan_q       <= 4'b1111;
      settle_q     <= '0;
      col_seen_q   <= '0;
      hit_q        <= 1'b0;
      multi_q      <= 1'b0;
      code_q       <= '0;
      round_done_q <= 1'b0;
      round_res_q  <= RES_NONE;
      round_code_q <= '0;
    end else begin
      scan_q       <= scan_d;
      settle_q     <= settle_d;
      col_seen_q   <= col_seen_d;
      hit_q        <= hit_d;
      multi_q      <= multi_d;
      code_q       <= code_d;
      round_done_q <= round_done_d;
      round_res_q  <= round_res_d;
      round_code_q <= round_code_d;
    end
  end

  assign round_done = round_done_q;
  assign round_res  = round_res_q;
  assign round_code = round_code_q;

endmodule

// File: rtl/keypad_key_debounce.sv
// rtl/keypad_key_debounce.sv - debounced key event generator for a 4x4 hex keypad
//
// Purpose: turns complete scan rounds into one key event per physical press,
// requiring DEB_ROUNDS identical rounds to accept a press or a release.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while held,
// first at RPT_DELAY rounds after acceptance, then every RPT_RATE rounds).
// Ports:
//   Clk, Rst   clock, synchronous active-high reset
//   kp         keypad_key_debounce_if.slave: scan/read in, key_code,
//              key_valid, key_held, multi_err out
module keypad_key_debounce
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DEB_ROUNDS = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int RPT_DELAY  = 25,
  parameter int RPT_RATE   = 5
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst,
  keypad_key_debounce_if.slave  kp
);

  localparam logic [7:0] DEB_LIM = 8'(DEB_ROUNDS);

  logic       round_done;
  round_res_e round_res;
  logic [3:0] round_code;

  keypad_round_sampler #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_sampler (
    .Clk        (Clk),
    .Rst        (Rst),
    .scan       (kp.scan),
    .read       (kp.read),
    .round_done (round_done),
    .round_res  (round_res),
    .round_code (round_code)
  );

  key_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       multi_err_q, multi_err_d;

  logic [7:0] cnt_inc;
  logic       is_one;
  logic       is_none;
  logic       accept;
  logic [3:0] accept_code;
  logic       released;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] RPT_DELAY_L = 8'(RPT_DELAY);
  localparam logic [7:0] RPT_RATE_L  = 8'(RPT_RATE);

  logic [7:0] rpt_cnt_q, rpt_cnt_d;
  logic       rpt_first_q, rpt_first_d;
  logic [7:0] rpt_nxt;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_err_d = 1'b0;
    cnt_inc     = sat_inc8(cnt_q);
    is_one      = (round_res == RES_ONE);
    is_none     = (round_res == RES_NONE);
    accept      = 1'b0;
    accept_code = round_code;
    released    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_nxt     = sat_inc8(rpt_cnt_q);
`endif

    if (round_done) begin
      multi_err_d = (round_res == RES_MULTI);
      case (state_q)
        ST_IDLE: begin
          if (is_one) begin
            cand_d = round_code;
            // With a single-round debounce there is no PRESS dwell.
            if (8'd1 >= DEB_LIM) begin
              accept = 1'b1;
            end else begin
              state_d = ST_PRESS;
              cnt_d   = 8'd1;
            end
          end
        end
        ST_PRESS: begin
          if (is_one && (round_code == cand_q)) begin
            if (cnt_inc >= DEB_LIM) begin
              accept      = 1'b1;
              accept_code = cand_q;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_one) begin
            cand_d = round_code;
            cnt_d  = 8'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            if (8'd1 >= DEB_LIM) begin
              released = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = 8'd1;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            // Count rounds spent held; first target is the initial delay,
            // afterwards the repeat period.
            if (rpt_nxt == (rpt_first_q ? RPT_RATE_L : RPT_DELAY_L)) begin
              key_valid_d = 1'b1;
              rpt_cnt_d   = 8'd0;
              rpt_first_d = 1'b1;
            end else begin
              rpt_cnt_d = rpt_nxt;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (is_none) begin
            if (cnt_inc >= DEB_LIM) begin
              released = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_one && (round_code == key_code_q)) begin
            // Release bounce: same key back, resume holding without a new event.
            state_d = ST_HELD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase

      if (accept) begin
        state_d     = ST_HELD;
        cnt_d       = 8'd0;
        key_code_d  = accept_code;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
      end
      if (released) begin
        state_d    = ST_IDLE;
        cnt_d      = 8'd0;
        key_held_d = 1'b0;
      end
    end

`ifdef KEYPAD_REPEAT_EN
    if (state_d != ST_HELD) begin
      rpt_cnt_d   = 8'd0;
      rpt_first_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.multi_err = multi_err_q;

endmodule
